// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war round logic: FSM state encoding and
// the 16-bit Fibonacci LFSR polynomial (taps 16,14,13,11).
package tow_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_ARM    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_LIT    = 3'd2,
    ST_RESULT = 3'd3,
    ST_STOP   = 3'd4
  } round_state_e;

  localparam int LFSR_W = 16;
  // Bit mask of taps 16,14,13,11 (1-based), i.e. bits 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/round_arbiter_if.sv
// Button inputs and scorer-facing controls of the round arbiter.
// The slave side is the arbiter; the master side drives the buttons and game_over.
interface round_arbiter_if;
  import tow_pkg::*;

  logic               pbl;
  logic               pbr;
  logic               game_over;
  logic               leds_on;
  logic               winrnd;
  logic               right;
  logic               tie;
  logic [STATE_W-1:0] round_state;

  modport master (
    output pbl, pbr, game_over,
    input  leds_on, winrnd, right, tie, round_state
  );

  modport slave (
    input  pbl, pbr, game_over,
    output leds_on, winrnd, right, tie, round_state
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances every clock, reset loads seed.
// A zero state (only reachable from a zero seed) is kicked back to 1.
module lfsr16
  import tow_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    if (lfsr_d == '0) begin
      lfsr_d = LFSR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/round_arbiter.sv
// Round sequencer for tug-of-war: random LEDs-off wait, lamp, first-push arbitration, 1-cycle winrnd.
// Define ROUND_TIMEOUT_EN to force a tie after LIT_TIMEOUT cycles lit with no press.
module round_arbiter
  import tow_pkg::*;
#(
  parameter logic [15:0] DELAY_MIN   = 16'd5000,
  parameter int          DELAY_W     = 12,
  parameter logic [7:0]  HOLD_CYCLES = 8'd100,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [23:0] LIT_TIMEOUT = 24'd1000000
) (
  input  logic             clk,
  input  logic             rst,
  round_arbiter_if.slave   ra
);

  round_state_e      state_q, state_d;
  logic [7:0]        rel_cnt_q, rel_cnt_d;
  logic [16:0]       dly_q, dly_d;
  logic              leds_q, leds_d;
  logic              win_q, win_d;
  logic              right_q, right_d;
  logic              tie_q, tie_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [16:0]       dly_load;
  logic              press;
  logic              both;
  logic              lfsr_hi_unused;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign press          = ra.pbl | ra.pbr;
  assign both           = ra.pbl & ra.pbr;
  assign dly_load       = {1'b0, DELAY_MIN} + {{(17-DELAY_W){1'b0}}, lfsr_q[DELAY_W-1:0]};
  assign lfsr_hi_unused = ^lfsr_q[LFSR_W-1:DELAY_W];

`ifdef ROUND_TIMEOUT_EN
  logic [23:0] lit_cnt_q, lit_cnt_d;
`else
  localparam logic [23:0] LIT_TIMEOUT_UNUSED = LIT_TIMEOUT;
`endif

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    dly_d     = dly_q;
    leds_d    = 1'b0;
    win_d     = 1'b0;
    right_d   = 1'b0;
    tie_d     = 1'b0;
`ifdef ROUND_TIMEOUT_EN
    lit_cnt_d = '0;
`endif
    if (ra.game_over) begin
      state_d = ST_STOP;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (press) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q == HOLD_CYCLES - 8'd1) begin
            rel_cnt_d = '0;
            dly_d     = dly_load;
            state_d   = ST_WAIT;
          end else begin
            rel_cnt_d = rel_cnt_q + 8'd1;
          end
        end
        ST_WAIT: begin
          // An early push is reported with the lamps still dark.
          if (press) begin
            state_d = ST_RESULT;
            win_d   = 1'b1;
            right_d = ra.pbr & ~ra.pbl;
            tie_d   = both;
          end else if (dly_q == '0) begin
            state_d = ST_LIT;
            leds_d  = 1'b1;
          end else begin
            dly_d = dly_q - 17'd1;
          end
        end
        ST_LIT: begin
          leds_d = 1'b1;
          if (press) begin
            state_d = ST_RESULT;
            win_d   = 1'b1;
            right_d = ra.pbr & ~ra.pbl;
            tie_d   = both;
          end
`ifdef ROUND_TIMEOUT_EN
          else if (lit_cnt_q == LIT_TIMEOUT - 24'd1) begin
            state_d = ST_RESULT;
            win_d   = 1'b1;
            tie_d   = 1'b1;
          end else begin
            lit_cnt_d = lit_cnt_q + 24'd1;
          end
`endif
        end
        ST_RESULT: begin
          state_d   = ST_ARM;
          rel_cnt_d = '0;
        end
        ST_STOP: begin
          state_d = ST_STOP;
        end
        default: begin
          state_d   = ST_ARM;
          rel_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARM;
      rel_cnt_q <= '0;
      dly_q     <= '0;
      leds_q    <= 1'b0;
      win_q     <= 1'b0;
      right_q   <= 1'b0;
      tie_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
      dly_q     <= dly_d;
      leds_q    <= leds_d;
      win_q     <= win_d;
      right_q   <= right_d;
      tie_q     <= tie_d;
    end
  end

`ifdef ROUND_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lit_cnt_q <= '0;
    end else begin
      lit_cnt_q <= lit_cnt_d;
    end
  end
`endif

  assign ra.leds_on     = leds_q;
  assign ra.winrnd      = win_q;
  assign ra.right       = right_q;
  assign ra.tie         = tie_q;
  assign ra.round_state = state_q;

endmodule

// File: tb/tb_round_arbiter.sv
// Randomized round-level bench for round_arbiter: a timeline model predicts each round's
// state sequence and result, a scoreboard queue holds expected winrnd pulses.
module tb_round_arbiter;

  localparam int          P_DMIN = 4;
  localparam int          P_DW   = 3;
  localparam int          P_HOLD = 2;
  localparam int          P_TO   = 20;
  localparam logic [15:0] P_SEED = 16'h0001;
  localparam int          S_ARM = 0, S_WAIT = 1, S_LIT = 2, S_RESULT = 3, S_STOP = 4;
  localparam int          NREF = 4096;

  typedef struct {
    int at;
    bit right;
    bit tie;
    bit leds;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   w;
  bit   prev_win;
  exp_t mon_e;
  exp_t sb[$];
  int   exp_state[int];
  bit   exp_leds[int];
  logic [15:0] lref [0:NREF-1];

  round_arbiter_if ra();

  round_arbiter #(
    .DELAY_MIN   (16'(P_DMIN)),
    .DELAY_W     (P_DW),
    .HOLD_CYCLES (8'(P_HOLD)),
    .LFSR_SEED   (P_SEED),
    .LIT_TIMEOUT (24'(P_TO))
  ) dut (
    .clk (clk),
    .rst (rst),
    .ra  (ra)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release: after edge n the DUT has seen n clocks.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) tick();
  endtask

  task automatic fill(input int from, input int to, input int st, input bit leds);
    for (int e = from; e <= to; e++) begin
      exp_state[e] = st;
      exp_leds[e]  = leds;
    end
  endtask

  function automatic int delay_for(input int wedge);
    int v;
    v = int'(lref[wedge-1]);
    return P_DMIN + (v % (1 << P_DW));
  endfunction

  task automatic check_reset_values();
    check("rst_leds_on", ra.leds_on, 0);
    check("rst_winrnd", ra.winrnd, 0);
    check("rst_right", ra.right, 0);
    check("rst_tie", ra.tie, 0);
    check("rst_state", ra.round_state, S_ARM);
    check("rst_lfsr", dut.lfsr_q, P_SEED);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    exp_state.delete();
    exp_leds.delete();
    rst = 1'b0;
    w = P_HOLD;
    fill(1, w - 1, S_ARM, 1'b0);
  endtask

  // mode 0: early push, 1: push while lit, 2: no push (timeout) / very late push.
  task automatic do_round(input int mode, input int sel_in, input int koff, input int hold);
    int d, lit, k, sel, r;
    bit r_exp, t_exp, l_exp;
    d   = delay_for(w);
    lit = w + d + 1;
    sel = (sel_in == 0) ? int'($urandom_range(1, 3)) : sel_in;
    case (mode)
      0:       k = w + 1 + ((koff >= 0) ? koff : int'($urandom_range(0, lit - w - 1)));
      1:       k = lit + 1 + ((koff >= 0) ? koff : int'($urandom_range(0, 15)));
      default: begin
`ifdef ROUND_TIMEOUT_EN
        k   = lit + P_TO;
        sel = 0;
`else
        k   = lit + 40;
`endif
      end
    endcase
    l_exp = (k > lit);
    r_exp = (sel == 2);
    t_exp = (sel == 3) || (sel == 0);
    fill(w, lit - 1, S_WAIT, 1'b0);
    if (k > lit) fill(lit, k - 1, S_LIT, 1'b1);
    fill(k, k, S_RESULT, l_exp);
    r = (k + hold + 1 > k + 2) ? k + hold + 1 : k + 2;
    fill(k + 1, r + P_HOLD - 2, S_ARM, 1'b0);
    sb.push_back('{k, r_exp, t_exp, l_exp});
    wait_edge(k - 1);
    ra.pbl = sel[0];
    ra.pbr = sel[1];
    tick();
    repeat (hold) tick();
    ra.pbl = 1'b0;
    ra.pbr = 1'b0;
    w = r + P_HOLD - 1;
  endtask

  task automatic game_over_then_reset();
    int g;
    g = w + 1 + int'($urandom_range(0, 2));
    fill(w, g - 1, S_WAIT, 1'b0);
    fill(g, g + 8, S_STOP, 1'b0);
    wait_edge(g - 1);
    ra.game_over = 1'b1;
    ra.pbl = 1'b1;
    ra.pbr = 1'b1;
    wait_edge(g + 8);
    check("stop_no_pending", sb.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    ra.game_over = 1'b0;
    ra.pbl = 1'b0;
    ra.pbr = 1'b0;
    release_reset();
  endtask

  task automatic reset_mid_lit();
    int lit;
    lit = w + delay_for(w) + 1;
    fill(w, lit - 1, S_WAIT, 1'b0);
    fill(lit, lit + 3, S_LIT, 1'b1);
    wait_edge(lit + 3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    release_reset();
  endtask

  // Monitor: per-cycle timeline checks plus scoreboard pops on winrnd.
  initial begin
    prev_win = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cyc < NREF) check("lfsr", dut.lfsr_q, lref[cyc]);
        check("lfsr_nonzero", int'(dut.lfsr_q != 16'h0), 1);
        if (exp_state.exists(cyc)) begin
          check("round_state", ra.round_state, exp_state[cyc]);
          check("leds_on", ra.leds_on, exp_leds[cyc]);
        end
        if (sb.size() > 0 && sb[0].at < cyc) begin
          check("winrnd_missing", cyc, sb[0].at);
          void'(sb.pop_front());
        end
        if (ra.winrnd) begin
          if (sb.size() == 0) begin
            check("winrnd_unexpected", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            check("winrnd_edge", cyc, mon_e.at);
            check("right", ra.right, mon_e.right);
            check("tie", ra.tie, mon_e.tie);
            check("result_leds_on", ra.leds_on, mon_e.leds);
          end
        end else if (prev_win) begin
          check("post_right", ra.right, 0);
          check("post_tie", ra.tie, 0);
        end
        prev_win = ra.winrnd;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    vectors      = 0;
    miscompares  = 0;
    lref[0] = P_SEED;
    for (int i = 1; i < NREF; i++) begin
      lref[i] = {lref[i-1][14:0], lref[i-1][15] ^ lref[i-1][13] ^ lref[i-1][12] ^ lref[i-1][10]};
    end
    ra.pbl       = 1'b0;
    ra.pbr       = 1'b0;
    ra.game_over = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    release_reset();

    do_round(0, 1, 0, 10);
    do_round(1, 2, 2, 0);
    do_round(1, 3, -1, 0);
    do_round(2, 0, -1, 0);
    for (int i = 0; i < 40; i++) begin
      m = int'($urandom_range(0, 4));
      do_round((m < 2) ? m : ((m == 4) ? 2 : 1), 0, -1, int'($urandom_range(0, 3)));
    end

    reset_mid_lit();
    do_round(1, 0, -1, 1);
    game_over_then_reset();
    do_round(0, 0, -1, 0);
    do_round(1, 0, -1, 0);
    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_arbiter.md
Name: round_arbiter

Overview:
- Sequences each round of the tug-of-war game and produces the scorer's control inputs: `winrnd`, `right`, `leds_on` and `tie`.
- Times a pseudo-random wait with the LEDs off, then lights the LEDs.
- Arbitrates the two player pushbuttons to decide who pushed first and whether the push was early (jumped the light).
- Sits between the synchronised/debounced button inputs and the scorer; all outputs are registered so the scorer sees glitch-free controls.

Parameters:
- DELAY_MIN, 16'd5000, minimum LEDs-off wait in clk cycles.
- DELAY_W, 12, LFSR bits added to DELAY_MIN; random span is 0..2^DELAY_W-1.
- HOLD_CYCLES, 8'd100, consecutive cycles both buttons must read released before the next round arms.
- LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit LFSR.
- LIT_TIMEOUT, 24'd1000000, cycles in LIT before a forced tie (used only with ROUND_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- pbl  input  1  left pushbutton, already synchronised, active-high
- pbr  input  1  right pushbutton, already synchronised, active-high
- game_over  input  1  high while the scorer shows a win; stops further rounds
- leds_on  output  1  round lamps lit; also qualifies the push during the winrnd pulse
- winrnd  output  1  one-cycle pulse: a round result is presented
- right  output  1  during winrnd: 1 = right pushed first, 0 = left
- tie  output  1  during winrnd: both pushed in the same cycle
- round_state  output  3  current FSM state, for debug/display

Behaviour:
- Reset values: leds_on=0, winrnd=0, right=0, tie=0, state=ARM, LFSR=LFSR_SEED, counters=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle regardless of state, never all-zero.
- ARM:
  - Release counter increments while pbl=0 and pbr=0, clears on any press.
  - When it reaches HOLD_CYCLES-1: load delay = DELAY_MIN + LFSR[DELAY_W-1:0] (zero-extended, 17-bit sum, no overflow) and go to WAIT.
- WAIT (leds_on=0):
  - Delay counter decrements each cycle; at 0 go to LIT.
  - A press while in WAIT goes to RESULT with leds_on held 0 (early push).
- LIT (leds_on=1): any press goes to RESULT with leds_on held 1.
- Press resolution (WAIT and LIT):
  - Exactly one of pbl/pbr high: right=pbr, tie=0.
  - Both high in the same cycle: tie=1, right=0.
- RESULT:
  - Lasts exactly one cycle with winrnd=1.
  - right, tie and leds_on are stable for that whole cycle.
  - Latency: a press sampled at edge k gives winrnd=1 in the cycle after edge k (one cycle).
  - The next state is ARM; leds_on, right and tie return to 0 on that edge.
- game_over:
  - Has priority in every state; the FSM goes to STOP on the next edge.
  - A RESULT already registered completes its single pulse.
  - STOP: all outputs 0. Leaving STOP to ARM requires game_over=0 and is only reachable via rst.
- Buttons held across rounds: ARM blocks until released, so one press never yields two winrnd pulses.
- Reset mid-round: state, outputs and LFSR return asynchronously to their reset values.
- round_state encoding: ARM=0, WAIT=1, LIT=2, RESULT=3, STOP=4. Values 5–7 are illegal and recover to ARM on the next edge.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN.
- Defined: a counter runs in LIT. After LIT_TIMEOUT cycles with no press, the FSM enters RESULT with tie=1, leds_on=1, right=0. The scorer holds its score and the round re-arms.
- Undefined: LIT waits indefinitely; the LIT_TIMEOUT parameter is ignored and no counter is synthesised.

Decomposition:
- Shared package `tow_pkg` holds:
  - state encodings ARM..STOP and the state width (3);
  - the LFSR width (16) and tap constants.
- One sub-module, `lfsr16`: ports clk, rst, seed, q[15:0]; free-running.
- Press resolution and the delay counter stay inline.

Test Plan:
- Bench parameters: DELAY_MIN=4, DELAY_W=3, HOLD_CYCLES=2, LFSR_SEED=16'h0001, LIT_TIMEOUT=20.
- Reset, no presses: ARM→WAIT after 2 cycles, delay 4+LFSR[2:0], then leds_on=1. No winrnd ever; LFSR never 0 over 1000 cycles.
- Press pbr 3 cycles into LIT: exactly one winrnd cycle with right=1, tie=0, leds_on=1; the next cycle leds_on=0 and state=ARM.
- Press pbl 1 cycle into WAIT: winrnd=1, right=0, tie=0, leds_on=0 (early push). Holding pbl 10 more cycles keeps ARM and gives no second pulse.
- pbl and pbr rise in the same LIT cycle: winrnd=1, tie=1, right=0. With ROUND_TIMEOUT_EN and no press: tie pulse exactly 20 cycles after LIT entry.
- game_over asserted in WAIT: STOP next edge with leds_on=0 and no winrnd despite presses. Asserting rst mid-LIT clears all outputs asynchronously and state=ARM.
